// File: rtl/seg14_pkg.sv
// seg14_pkg: shared definitions for 14-segment display blocks.
//   - character codes (0-9 digits, 10-35 A-Z, 36 N-tilde, 63 space)
//   - segment bit positions within the 14-bit pattern
//   - font patterns, one localparam per displayable character
package seg14_pkg;

  localparam logic [5:0] CH_0 = 6'd0,  CH_1 = 6'd1,  CH_2 = 6'd2,  CH_3 = 6'd3;
  localparam logic [5:0] CH_4 = 6'd4,  CH_5 = 6'd5,  CH_6 = 6'd6,  CH_7 = 6'd7;
  localparam logic [5:0] CH_8 = 6'd8,  CH_9 = 6'd9;
  localparam logic [5:0] CH_A = 6'd10, CH_B = 6'd11, CH_C = 6'd12, CH_D = 6'd13;
  localparam logic [5:0] CH_E = 6'd14, CH_F = 6'd15, CH_G = 6'd16, CH_H = 6'd17;
  localparam logic [5:0] CH_I = 6'd18, CH_J = 6'd19, CH_K = 6'd20, CH_L = 6'd21;
  localparam logic [5:0] CH_M = 6'd22, CH_N = 6'd23, CH_O = 6'd24, CH_P = 6'd25;
  localparam logic [5:0] CH_Q = 6'd26, CH_R = 6'd27, CH_S = 6'd28, CH_T = 6'd29;
  localparam logic [5:0] CH_U = 6'd30, CH_V = 6'd31, CH_W = 6'd32, CH_X = 6'd33;
  localparam logic [5:0] CH_Y = 6'd34, CH_Z = 6'd35;
  localparam logic [5:0] CH_ENE   = 6'd36;
  localparam logic [5:0] CH_SPACE = 6'd63;

  // Segment bit positions. h/j/k/m are the four diagonals,
  // i/l the upper and lower centre verticals.
  localparam int unsigned SEG_A  = 13, SEG_B  = 12, SEG_C = 11, SEG_D = 10;
  localparam int unsigned SEG_E  = 9,  SEG_F  = 8;
  localparam int unsigned SEG_G1 = 7,  SEG_G2 = 6;
  localparam int unsigned SEG_H  = 5,  SEG_I  = 4,  SEG_J = 3;
  localparam int unsigned SEG_K  = 2,  SEG_L  = 1,  SEG_M = 0;

  localparam logic [13:0] FONT_0 = 14'h3F0C, FONT_1 = 14'h1800, FONT_2 = 14'h36C0;
  localparam logic [13:0] FONT_3 = 14'h3CC0, FONT_4 = 14'h19C0, FONT_5 = 14'h2DC0;
  localparam logic [13:0] FONT_6 = 14'h2FC0, FONT_7 = 14'h3800, FONT_8 = 14'h3FC0;
  localparam logic [13:0] FONT_9 = 14'h3DC0;
  localparam logic [13:0] FONT_A = 14'h3BC0, FONT_B = 14'h3C52, FONT_C = 14'h2700;
  localparam logic [13:0] FONT_D = 14'h3C12, FONT_E = 14'h2780, FONT_F = 14'h2380;
  localparam logic [13:0] FONT_G = 14'h2F40, FONT_H = 14'h1BC0, FONT_I = 14'h2412;
  localparam logic [13:0] FONT_J = 14'h1E00, FONT_K = 14'h0389, FONT_L = 14'h0700;
  localparam logic [13:0] FONT_M = 14'h1B28, FONT_N = 14'h1B21, FONT_O = 14'h3F00;
  localparam logic [13:0] FONT_P = 14'h33C0, FONT_Q = 14'h3F01, FONT_R = 14'h33C1;
  localparam logic [13:0] FONT_S = 14'h2DC0, FONT_T = 14'h2012, FONT_U = 14'h1F00;
  localparam logic [13:0] FONT_V = 14'h030C, FONT_W = 14'h1B05, FONT_X = 14'h002D;
  localparam logic [13:0] FONT_Y = 14'h002A, FONT_Z = 14'h240C;
  localparam logic [13:0] FONT_ENE   = 14'h3B21;
  localparam logic [13:0] FONT_BLANK = 14'h0000;

endpackage

// File: rtl/seg14_font.sv
// seg14_font: combinational character-code to 14-segment pattern decoder.
//   code    in  6   character code
//   pattern out 14  segment pattern ([13:8]=a..f, [7:6]=g1,g2, [5:0]=h..m)
// Space and every unassigned code decode to blank.
module seg14_font
  import seg14_pkg::*;
(
  input  logic [5:0]  code,
  output logic [13:0] pattern
);

  always_comb begin
    pattern = FONT_BLANK;
    case (code)
      CH_0: pattern = FONT_0;   CH_1: pattern = FONT_1;
      CH_2: pattern = FONT_2;   CH_3: pattern = FONT_3;
      CH_4: pattern = FONT_4;   CH_5: pattern = FONT_5;
      CH_6: pattern = FONT_6;   CH_7: pattern = FONT_7;
      CH_8: pattern = FONT_8;   CH_9: pattern = FONT_9;
      CH_A: pattern = FONT_A;   CH_B: pattern = FONT_B;
      CH_C: pattern = FONT_C;   CH_D: pattern = FONT_D;
      CH_E: pattern = FONT_E;   CH_F: pattern = FONT_F;
      CH_G: pattern = FONT_G;   CH_H: pattern = FONT_H;
      CH_I: pattern = FONT_I;   CH_J: pattern = FONT_J;
      CH_K: pattern = FONT_K;   CH_L: pattern = FONT_L;
      CH_M: pattern = FONT_M;   CH_N: pattern = FONT_N;
      CH_O: pattern = FONT_O;   CH_P: pattern = FONT_P;
      CH_Q: pattern = FONT_Q;   CH_R: pattern = FONT_R;
      CH_S: pattern = FONT_S;   CH_T: pattern = FONT_T;
      CH_U: pattern = FONT_U;   CH_V: pattern = FONT_V;
      CH_W: pattern = FONT_W;   CH_X: pattern = FONT_X;
      CH_Y: pattern = FONT_Y;   CH_Z: pattern = FONT_Z;
      CH_ENE: pattern = FONT_ENE;
      default: pattern = FONT_BLANK;
    endcase
  end

endmodule

// File: rtl/seg14_scroll_scanner.sv
// seg14_scroll_scanner: multiplexed 14-segment display driver with an
// optional scrolling message.
//   clk, rst_n  scan clock, asynchronous active-low reset
//   wr_en, wr_addr, wr_char  message buffer write port
//   msg_len     active message length (clamped to MSG_DEPTH)
//   scroll_en   advance the message by one character every SCROLL_DIV frames
//   sel         registered one-hot digit select
//   segm        registered segment pattern of the selected digit
module seg14_scroll_scanner
  import seg14_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 12,
  parameter int unsigned MSG_DEPTH  = 32,
  parameter int unsigned SCAN_DIV   = 1,
  parameter int unsigned SCROLL_DIV = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [5:0]                   wr_char,
  input  logic [$clog2(MSG_DEPTH):0]   msg_len,
  input  logic                         scroll_en,
  output logic [NUM_DIGITS-1:0]        sel,
  output logic [13:0]                  segm
);

  localparam int unsigned AW = $clog2(MSG_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = $clog2(NUM_DIGITS);
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(SCROLL_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [LW-1:0] DEPTH_L    = LW'(MSG_DEPTH);

  logic [5:0]    mem [MSG_DEPTH];
  logic [CW-1:0] scan_cnt;
  logic [DW-1:0] digit_idx;
  logic [FW-1:0] frame_cnt;
  logic [AW-1:0] ptr, ptr_nxt, offset, offset_nxt, rd_idx;
  logic [LW-1:0] len;
  logic          tick, frame_wrap, scroll_step, ptr_bad;
  logic [13:0]   font_pat;

  always_comb begin
    len         = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
    tick        = (scan_cnt == SCAN_LAST);
    frame_wrap  = tick && (digit_idx == DIGIT_LAST);
    scroll_step = scroll_en && frame_wrap && (frame_cnt == FRAME_LAST);
    ptr_bad     = ({1'b0, ptr} >= len);

    // A stale offset (msg_len shrank) is cleared before any scroll step.
    offset_nxt = offset;
    if ({1'b0, offset} >= len)
      offset_nxt = '0;
    else if (scroll_step)
      offset_nxt = (({1'b0, offset} + LW'(1)) >= len) ? '0 : offset + 1'b1;

    // The frame start loads the offset being written this cycle, so a
    // scroll step shows up on the very next frame and never mid-frame.
    ptr_nxt = ptr;
    if (frame_wrap)
      ptr_nxt = offset_nxt;
    else if (ptr_bad)
      ptr_nxt = '0;
    else if (tick)
      ptr_nxt = (({1'b0, ptr} + LW'(1)) >= len) ? '0 : ptr + 1'b1;

    // An out-of-range pointer reads entry 0, the value it is about to take,
    // so no character past msg_len ever reaches the segments.
    rd_idx = ptr_bad ? '0 : ptr;
  end

  seg14_font u_font (
    .code    (mem[rd_idx]),
    .pattern (font_pat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MSG_DEPTH; i++) mem[i] <= CH_SPACE;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
      frame_cnt <= '0;
      ptr       <= '0;
      offset    <= '0;
      sel       <= '0;
      segm      <= '0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
      if (tick)
        digit_idx <= (digit_idx == DIGIT_LAST) ? '0 : digit_idx + 1'b1;
      if (!scroll_en)
        frame_cnt <= '0;
      else if (frame_wrap)
        frame_cnt <= (frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;
      ptr    <= ptr_nxt;
      offset <= offset_nxt;
      sel    <= NUM_DIGITS'(1) << digit_idx;
      segm   <= (len == '0) ? '0 : font_pat;
    end
  end

endmodule

// File: tb/tb_seg14_scroll_scanner.sv
module tb_seg14_scroll_scanner;

  localparam int unsigned N  = 12;
  localparam int unsigned D  = 32;
  localparam int unsigned SD = 1;
  localparam int unsigned SR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [5:0]  wr_char = '0;
  logic [5:0]  msg_len = 6'd12;
  logic        scroll_en = 1'b0;
  logic [11:0] sel;
  logic [13:0] segm;

  int total = 0;
  int bad = 0;

  int unsigned msg [12] = '{12, 17, 27, 18, 28, 29, 18, 10, 23, 9, 8, 2};

  seg14_scroll_scanner #(
    .NUM_DIGITS (N),
    .MSG_DEPTH  (D),
    .SCAN_DIV   (SD),
    .SCROLL_DIV (SR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_char   (wr_char),
    .msg_len   (msg_len),
    .scroll_en (scroll_en),
    .sel       (sel),
    .segm      (segm)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] font_of(input logic [5:0] c);
    case (c)
      6'd0:  return 14'h3F0C;  6'd1:  return 14'h1800;  6'd2:  return 14'h36C0;
      6'd3:  return 14'h3CC0;  6'd4:  return 14'h19C0;  6'd5:  return 14'h2DC0;
      6'd6:  return 14'h2FC0;  6'd7:  return 14'h3800;  6'd8:  return 14'h3FC0;
      6'd9:  return 14'h3DC0;  6'd10: return 14'h3BC0;  6'd11: return 14'h3C52;
      6'd12: return 14'h2700;  6'd13: return 14'h3C12;  6'd14: return 14'h2780;
      6'd15: return 14'h2380;  6'd16: return 14'h2F40;  6'd17: return 14'h1BC0;
      6'd18: return 14'h2412;  6'd19: return 14'h1E00;  6'd20: return 14'h0389;
      6'd21: return 14'h0700;  6'd22: return 14'h1B28;  6'd23: return 14'h1B21;
      6'd24: return 14'h3F00;  6'd25: return 14'h33C0;  6'd26: return 14'h3F01;
      6'd27: return 14'h33C1;  6'd28: return 14'h2DC0;  6'd29: return 14'h2012;
      6'd30: return 14'h1F00;  6'd31: return 14'h030C;  6'd32: return 14'h1B05;
      6'd33: return 14'h002D;  6'd34: return 14'h002A;  6'd35: return 14'h240C;
      6'd36: return 14'h3B21;
      default: return 14'h0000;
    endcase
  endfunction

  function automatic int unsigned clamp_len(input logic [5:0] l);
    return (int'(l) > int'(D)) ? D : int'(l);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: digit d of frame f shows entry (frame_offset + d) mod len.
  // After msg_len changes the positions are only defined again from the next
  // frame start, so segm is not compared against the model until then.
  logic [5:0]  m_mem [D];
  int unsigned m_k = 0, m_off = 0, m_frame_off = 0, m_fcnt = 0, m_prev_len = 12;
  bit          m_dirty = 1'b0;
  logic [11:0] exp_sel = '0;
  logic [13:0] exp_segm = '0;
  bit          exp_valid = 1'b1;
  bit          cmp_on = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(D); i++) m_mem[i] = 6'd63;
      m_k = 0; m_off = 0; m_frame_off = 0; m_fcnt = 0;
      m_prev_len = clamp_len(msg_len);
      m_dirty = 1'b0;
      exp_sel = '0; exp_segm = '0; exp_valid = 1'b1;
    end else begin
      int unsigned len, d, pos;
      bit wrap, step;
      len = clamp_len(msg_len);
      if (len != m_prev_len) m_dirty = 1'b1;
      m_prev_len = len;
      d = (m_k / SD) % N;
      wrap = (d == N - 1) && ((m_k % SD) == SD - 1);
      exp_sel = 12'(1) << d;
      if (len == 0) begin
        exp_segm = '0;
        exp_valid = 1'b1;
      end else begin
        pos = (m_frame_off + d) % len;
        exp_segm = font_of(m_mem[pos]);
        exp_valid = !m_dirty;
      end
      step = 1'b0;
      if (!scroll_en) m_fcnt = 0;
      else if (wrap) begin
        m_fcnt++;
        if (m_fcnt == SR) begin m_fcnt = 0; step = 1'b1; end
      end
      if (m_off >= len) m_off = 0;
      else if (step) m_off = (m_off + 1) % len;
      if (wrap) begin
        m_frame_off = m_off;
        m_dirty = 1'b0;
      end
      if (wr_en) m_mem[wr_addr] = wr_char;
      m_k++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_sel", 32'(sel), 32'(exp_sel));
      if (exp_valid) chk("model_segm", 32'(segm), 32'(exp_segm));
    end
  end

  task automatic wait_sel(input logic [11:0] target, input int budget, input string name);
    int n = 0;
    while (sel !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sel !== target) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for sel 0x%0h, got 0x%0h", name, target, sel);
    end
  endtask

  task automatic next_frame(input string name);
    @(negedge clk);
    wait_sel(12'h001, 2 * N + 2, name);
  endtask

  initial begin
    bit in_set;
    repeat (3) @(negedge clk);
    chk("reset_sel", 32'(sel), 32'h0);
    chk("reset_segm", 32'(segm), 32'h0);
    rst_n = 1'b1;

    // Idle scan over a blank buffer.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      chk("idle_sel", 32'(sel), 32'(12'(1) << (i % 12)));
      chk("idle_segm", 32'(segm), 32'h0);
    end

    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_char = 6'(msg[i]);
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    wait_sel(12'h001, 2 * N + 2, "wait_msg");
    chk("msg_C", 32'(segm), 32'h2700);
    @(negedge clk);
    chk("msg_H", 32'(segm), 32'h1BC0);
    wait_sel(12'h200, 2 * N + 2, "wait_d9");
    chk("msg_9", 32'(segm), 32'h3DC0);
    @(negedge clk);
    chk("msg_8", 32'(segm), 32'h3FC0);
    @(negedge clk);
    chk("msg_2", 32'(segm), 32'h36C0);

    // Short message repeats across the remaining digits.
    msg_len = 6'd5;
    next_frame("wait_len5");
    @(negedge clk);
    next_frame("wait_len5b");
    repeat (5) @(negedge clk);
    chk("len5_sel5", 32'(sel), 32'h020);
    chk("len5_C", 32'(segm), 32'h2700);
    @(negedge clk);
    chk("len5_H", 32'(segm), 32'h1BC0);

    // Scrolling: one character every 2 frames.
    msg_len = 6'd12;
    next_frame("wait_scroll0");
    next_frame("wait_scroll1");
    scroll_en = 1'b1;
    for (int f = 1; f <= 44; f++) begin
      next_frame("wait_scroll");
      chk("scroll_frame", 32'(segm), 32'(font_of(6'(msg[(f / 2) % 12]))));
      if (f == 2)  chk("scroll_H", 32'(segm), 32'h1BC0);
      if (f == 24) chk("scroll_back_C", 32'(segm), 32'h2700);
    end
    chk("offset10_8", 32'(segm), 32'h3FC0);

    // Shrink msg_len under offset=10, ptr=11.
    scroll_en = 1'b0;
    msg_len = 6'd4;
    @(negedge clk);
    chk("offset_fix", 32'(dut.offset), 32'h0);
    for (int c = 0; c < int'(2 * N); c++) begin
      in_set = 1'b0;
      for (int j = 0; j < 4; j++) if (segm == font_of(6'(msg[j]))) in_set = 1'b1;
      chk("shrink_in_range", 32'(in_set), 32'h1);
      @(negedge clk);
    end
    next_frame("wait_len4");
    chk("len4_C", 32'(segm), 32'h2700);
    repeat (4) @(negedge clk);
    chk("len4_wrap_C", 32'(segm), 32'h2700);

    // Asynchronous reset mid-frame.
    msg_len = 6'd12;
    next_frame("wait_rst0");
    wait_sel(12'h080, 2 * N + 2, "wait_d7");
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel), 32'h0);
    chk("async_rst_segm", 32'(segm), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_sel", 32'(sel), 32'(12'(1) << i));
      chk("post_rst_segm", 32'(segm), 32'h0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      wr_addr = 5'($urandom);
      case ($urandom_range(0, 3))
        0, 1: wr_char = 6'($urandom_range(0, 36));
        2:    wr_char = 6'd63;
        default: wr_char = 6'($urandom);
      endcase
      if ($urandom_range(0, 149) == 0) msg_len = 6'($urandom_range(0, 40));
      if ($urandom_range(0, 99) == 0) scroll_en = ~scroll_en;
      @(negedge clk);
    end
    wr_en = 1'b0;
    @(negedge clk);
    cmp_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg14_scroll_scanner.md
# seg14_scroll_scanner

Parametrised multiplexed driver for a common-select 14-segment display bank. It holds a writable message buffer of character codes and time-multiplexes NUM_DIGITS digit selects, decoding each character through a 14-segment font. It can optionally scroll the message across the display. It sits between the host/config logic, which writes the text, and the pad-level digit-select and segment outputs.

## Interface
Parameters:
- NUM_DIGITS, 12, number of physical digits (one-hot select width), ≥2
- MSG_DEPTH, 32, message buffer entries, power of two, ≥NUM_DIGITS
- SCAN_DIV, 1, clocks per digit slot, ≥1
- SCROLL_DIV, 64, completed frames per one-character scroll step, ≥1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  scan clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe for message buffer
- wr_addr  in  $clog2(MSG_DEPTH)  buffer entry to write
- wr_char  in  6  character code
- msg_len  in  $clog2(MSG_DEPTH)+1  active message length, clamped to MSG_DEPTH
- scroll_en  in  1  enable scrolling
- sel  out  NUM_DIGITS  one-hot digit select, registered
- segm  out  14  segment pattern, registered; [13:8]=a..f, [7:6]=g1,g2, [5:0]=diagonal/centre segments

## Operation
- Character codes: 0–9 are digits; 10–35 are A–Z; 36 is Ñ; 63 is space; all other codes decode to blank (0).
- Reset values: sel=0, segm=0, digit_idx=0, ptr=0, offset=0, divider counters 0, every buffer entry = 63.
- Scan: divider counts 0..SCAN_DIV-1. On terminal count, digit_idx advances and wraps NUM_DIGITS-1→0. A wrap completes one frame.
- Character pointer ptr, no divider/modulo:
  - At the digit_idx→0 step, ptr loads offset.
  - Otherwise ptr increments, wrapping at msg_len-1→0.
- Every clock: sel ← one-hot(digit_idx); segm ← font(buf[ptr]).
- msg_len=0: segm forced to 0; sel keeps scanning.
- Digits beyond msg_len repeat the message (wrap), not blank.
- Scroll: with scroll_en=1, a frame counter counts completed frames. At SCROLL_DIV it clears and offset increments, wrapping at msg_len. With scroll_en=0, offset holds and the frame counter clears.
- If offset ≥ msg_len or ptr ≥ msg_len (msg_len shrank), the offending register is forced to 0 on the next clock.
- Writes: synchronous; wr_addr ≥ MSG_DEPTH cannot occur (power-of-two depth). A write and a display read of the same entry in one cycle: the display shows the old value that cycle and the new value on the next visit.
- Reset assertion mid-frame: all outputs go to reset values immediately (asynchronous); the buffer is cleared.

## Timing
- Latency: one clock from (digit_idx, ptr) to sel/segm.
- First clock edge after rst_n release gives sel=1 and segm=font(buf[0]).
- Each digit stays selected exactly SCAN_DIV clocks. Frame period = NUM_DIGITS·SCAN_DIV clocks.
- Scroll step period = SCROLL_DIV frames. The new offset takes effect at the next frame start, never mid-frame.
- sel is never multi-hot. It is all-zero only in reset.

## Structure
- Shared package seg14_pkg holds:
  - character code constants (CH_0…CH_9, CH_A…CH_Z, CH_ENE, CH_SPACE=63)
  - segment bit-index constants
  - the 14-bit font pattern localparams
- Sub-module seg14_font: purely combinational 6-bit code → 14-bit pattern, reusable by other display blocks.
- Buffer is a flop array with one write port and one read port.

## Test plan
- Reset then idle, SCAN_DIV=1, msg_len=12 → sel steps 0x001,0x002,…,0x800,0x001 on successive clocks; segm=0 throughout (buffer is spaces).
- Write "CHRISTIAN982" (codes 12,17,27,18,28,29,18,10,23,9,8,2) to entries 0–11, msg_len=12 → sel=0x001 shows segm=0x2700 (C), sel=0x002 shows 0x1BC0 (H), sel=0x200 shows 0x3DC0 (9), sel=0x400 shows 0x3FC0 (8), sel=0x800 shows 0x36C0 (2).
- Same message, msg_len=5 → digit 5 shows C (0x2700), digit 6 shows H; wrap is correct with no divider.
- scroll_en=1, SCROLL_DIV=2 → after 2 full frames, sel=0x001 shows H (0x1BC0); after 24 frames the display returns to C.
- Offset=10 with msg_len=12, then reduce msg_len to 4 → offset reads 0 one clock later and no out-of-range character appears.
- Assert rst_n mid-frame at digit 7 → sel=0 and segm=0 immediately; after release, scan restarts at sel=0x001 with a blank buffer.
